// File: rtl/ub_read_sequencer.sv
// Read-side initiator for the unified buffer: issues paired input/weight row
// address streams with first/last markers, then signals completion after read latency.

module ub_read_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] input_base,
  input  logic [ADDR_WIDTH-1:0] input_stride,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] weight_stride,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  hold,
  output logic                  issue_valid,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_first,
  output logic                  input_last,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_first,
  output logic                  weight_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH-1:0] in_acc_r;
  logic [ADDR_WIDTH-1:0] in_stride_r;
  logic [ADDR_WIDTH-1:0] wt_acc_r;
  logic [ADDR_WIDTH-1:0] wt_stride_r;
  logic [LEN_WIDTH-1:0]  last_idx_r;
  logic [LEN_WIDTH-1:0]  idx_r;
  logic                  accept_s;
  logic                  fire_s;
  logic                  at_last_s;

  // The done cycle already sits in IDLE, so a start seen there is masked by done.
  assign accept_s  = (state_r == ST_IDLE) && start && !done;
  assign fire_s    = (state_r == ST_ISSUE) && !hold;
  assign at_last_s = (idx_r == last_idx_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (length == {LEN_WIDTH{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (fire_s && at_last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Latched command, running address accumulators and row index.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_acc_r    <= {ADDR_WIDTH{1'b0}};
      in_stride_r <= {ADDR_WIDTH{1'b0}};
      wt_acc_r    <= {ADDR_WIDTH{1'b0}};
      wt_stride_r <= {ADDR_WIDTH{1'b0}};
      last_idx_r  <= {LEN_WIDTH{1'b0}};
      idx_r       <= {LEN_WIDTH{1'b0}};
    end else if (accept_s) begin
      in_acc_r    <= input_base;
      in_stride_r <= input_stride;
      wt_acc_r    <= weight_base;
      wt_stride_r <= weight_stride;
      last_idx_r  <= length - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      idx_r       <= {LEN_WIDTH{1'b0}};
    end else if (fire_s) begin
      in_acc_r <= in_acc_r + in_stride_r;
      wt_acc_r <= wt_acc_r + wt_stride_r;
      idx_r    <= idx_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      idx_r <= idx_r;
    end
  end

  // Registered request, marker and status outputs; addresses hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      input_addr   <= {ADDR_WIDTH{1'b0}};
      weight_addr  <= {ADDR_WIDTH{1'b0}};
      input_first  <= 1'b0;
      input_last   <= 1'b0;
      weight_first <= 1'b0;
      weight_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      issue_valid  <= fire_s;
      input_first  <= fire_s && (idx_r == {LEN_WIDTH{1'b0}});
      weight_first <= fire_s && (idx_r == {LEN_WIDTH{1'b0}});
      input_last   <= fire_s && at_last_s;
      weight_last  <= fire_s && at_last_s;
      busy         <= (state_r != ST_IDLE);
      done         <= (state_r == ST_DONE);
      if (fire_s) begin
        input_addr  <= in_acc_r;
        weight_addr <= wt_acc_r;
      end else begin
        input_addr  <= input_addr;
        weight_addr <= weight_addr;
      end
    end
  end

  ub_read_sequencer_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .input_first  (input_first),
    .input_last   (input_last),
    .weight_first (weight_first),
    .weight_last  (weight_last),
    .busy         (busy),
    .done         (done)
  );

endmodule

// Invariants of the registered output bundle.
module ub_read_sequencer_chk (
  input logic clk,
  input logic rst,
  input logic issue_valid,
  input logic input_first,
  input logic input_last,
  input logic weight_first,
  input logic weight_last,
  input logic busy,
  input logic done
);

  a_valid_busy: assert property (@(posedge clk) disable iff (rst) issue_valid |-> busy);
  a_done_busy:  assert property (@(posedge clk) disable iff (rst) done |-> busy);
  a_done_quiet: assert property (@(posedge clk) disable iff (rst) done |-> !issue_valid);
  a_marker_req: assert property (@(posedge clk) disable iff (rst)
                  !issue_valid |-> !(input_first || input_last || weight_first || weight_last));
  a_lockstep:   assert property (@(posedge clk) disable iff (rst)
                  (input_first == weight_first) && (input_last == weight_last));

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Randomized self-checking bench for ub_read_sequencer against a row-list reference model.

module tb_ub_read_sequencer;

  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] input_base, input_stride, weight_base, weight_stride;
  logic [LW-1:0] length;
  logic          hold;
  logic          issue_valid, input_first, input_last, weight_first, weight_last;
  logic [AW-1:0] input_addr, weight_addr;
  logic          busy, done;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] last_in  = '0;
  logic [AW-1:0] last_wt  = '0;

  always #5 clk = ~clk;

  ub_read_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_base(input_base), .input_stride(input_stride),
    .weight_base(weight_base), .weight_stride(weight_stride),
    .length(length), .hold(hold), .issue_valid(issue_valid),
    .input_addr(input_addr), .input_first(input_first), .input_last(input_last),
    .weight_addr(weight_addr), .weight_first(weight_first), .weight_last(weight_last),
    .busy(busy), .done(done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Non-request cycle: no valid, no markers, addresses hold their last value.
  task automatic check_quiet(input string tag, input bit exp_busy, input bit exp_done);
    check_val({tag, ".valid"}, 32'(issue_valid), 32'd0);
    check_val({tag, ".markers"}, {28'd0, input_first, input_last, weight_first, weight_last}, 32'd0);
    check_val({tag, ".in_addr"}, 32'(input_addr), 32'(last_in));
    check_val({tag, ".wt_addr"}, 32'(weight_addr), 32'(last_wt));
    check_val({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check_val({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic scramble_cmd();
    input_base    = AW'($urandom);
    input_stride  = AW'($urandom);
    weight_base   = AW'($urandom);
    weight_stride = AW'($urandom);
    length        = LW'($urandom);
  endtask

  // Runs one command; expected rows are ib + k*is, wb + k*ws (mod 2^AW).
  task automatic run_cmd(input logic [AW-1:0] ib, input logic [AW-1:0] is,
                         input logic [AW-1:0] wb, input logic [AW-1:0] ws,
                         input int len, input logic [31:0] hold_mask, input int hold_pct,
                         input bit collide, input int abort_row);
    int k = 0;
    int cyc = 0;
    bit h;
    input_base = ib; input_stride = is; weight_base = wb; weight_stride = ws;
    length = LW'(len); start = 1'b1; hold = 1'($urandom);
    step();
    start = 1'b0;
    check_quiet("accept", 1'b0, 1'b0);
    while (k < len) begin
      if (cyc < 32) h = hold_mask[cyc] || (($urandom_range(0, 99) < hold_pct) && cyc < 4 * len + 8);
      else          h = (($urandom_range(0, 99) < hold_pct) && cyc < 4 * len + 8);
      hold = h;
      cyc++;
      if (collide && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        scramble_cmd();
      end else begin
        start = 1'b0;
      end
      step();
      if (h) begin
        check_quiet("hold", 1'b1, 1'b0);
      end else begin
        last_in = AW'(32'(ib) + 32'(k) * 32'(is));
        last_wt = AW'(32'(wb) + 32'(k) * 32'(ws));
        check_val("row.valid", 32'(issue_valid), 32'd1);
        check_val("row.in_addr", 32'(input_addr), 32'(last_in));
        check_val("row.wt_addr", 32'(weight_addr), 32'(last_wt));
        check_val("row.in_first", 32'(input_first), 32'(k == 0));
        check_val("row.wt_first", 32'(weight_first), 32'(k == 0));
        check_val("row.in_last", 32'(input_last), 32'(k == len - 1));
        check_val("row.wt_last", 32'(weight_last), 32'(k == len - 1));
        check_val("row.busy", 32'(busy), 32'd1);
        check_val("row.done", 32'(done), 32'd0);
        if (k == abort_row) begin
          rst = 1'b1; start = 1'b0; hold = 1'b0;
          step();
          rst = 1'b0;
          last_in = '0;
          last_wt = '0;
          check_quiet("abort", 1'b0, 1'b0);
          for (int i = 0; i < 4; i++) begin
            step();
            check_quiet("post_abort", 1'b0, 1'b0);
          end
          return;
        end
        k++;
      end
    end
    if (len > 0) begin
      hold = 1'($urandom);
      start = collide;
      if (collide) scramble_cmd();
      step();
      check_quiet("drain", 1'b1, 1'b0);
    end
    hold = 1'($urandom);
    start = 1'b0;
    step();
    check_quiet("done", 1'b1, 1'b1);
    start = collide;
    if (collide) scramble_cmd();
    step();
    start = 1'b0;
    check_quiet("after_done", 1'b0, 1'b0);
    step();
    check_quiet("ignored_start", 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    input_base = '0; input_stride = '0; weight_base = '0; weight_stride = '0; length = '0;
    step();
    start = 1'b1;
    length = 8'd5;
    step();
    check_quiet("reset", 1'b0, 1'b0);
    start = 1'b0;
    rst = 1'b0;
    step();
    check_quiet("reset_idle", 1'b0, 1'b0);

    run_cmd(16'h0010, 16'h0001, 16'h0040, 16'h0001, 4, 32'h0, 0, 1'b0, -1);
    run_cmd(16'hFFFE, 16'h0003, 16'h1234, 16'h0000, 3, 32'h0, 0, 1'b0, -1);
    run_cmd(16'h0100, 16'h0010, 16'h0200, 16'h0020, 3, 32'h13, 0, 1'b0, -1);
    run_cmd(16'h0ABC, 16'h0007, 16'h0DEF, 16'h0009, 1, 32'h0, 0, 1'b0, -1);
    run_cmd(16'h1111, 16'h0001, 16'h2222, 16'h0001, 0, 32'h0, 0, 1'b1, -1);
    run_cmd(16'h3000, 16'h0004, 16'h4000, 16'h0008, 6, 32'h0, 0, 1'b1, -1);
    run_cmd(16'h5000, 16'h0002, 16'h6000, 16'h0003, 8, 32'h0, 0, 1'b0, 2);
    run_cmd(16'h7000, 16'h0005, 16'h8000, 16'h0006, 8, 32'h0, 0, 1'b0, -1);
    run_cmd(16'hFF00, 16'h0101, 16'h00FF, 16'hFFFF, 255, 32'h0, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(0, 12), 32'h0, 30, 1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
